// File: rtl/latch_ctrl_pkg.sv
// Shared types and helpers for the latch bank write controller.
package latch_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StOpen,
        StHold,
        StDone
    } state_e;

    // Width of the phase down-counter: enough for the largest CYC-1, never zero.
    function automatic int unsigned phase_cnt_w(input int unsigned setup_cyc,
                                                input int unsigned open_cyc,
                                                input int unsigned hold_cyc);
        int unsigned m;
        m = setup_cyc;
        if (open_cyc > m) m = open_cyc;
        if (hold_cyc > m) m = hold_cyc;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // After a grant the pointer moves to the requester that did not win.
    always_comb begin
        ptr_d = ptr_q;
        if (adv) begin
            ptr_d = ~gnt[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/latch_bank_ctrl.sv
// Sequences setup/open/hold writes into a latch bank shared by two round-robin requesters.
module latch_bank_ctrl
    import latch_ctrl_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter int unsigned N         = 4,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned OPEN_CYC  = 2,
    parameter int unsigned HOLD_CYC  = 1,
    localparam int unsigned AW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [W-1:0]  data0,
    input  logic [W-1:0]  data1,
    output logic [1:0]    gnt,
    output logic [1:0]    ack,
    output logic          busy,
    output logic          err,
    output logic [W-1:0]  lat_d,
    output logic [N-1:0]  lat_en
);

    localparam int unsigned CW = phase_cnt_w(SETUP_CYC, OPEN_CYC, HOLD_CYC);
    localparam logic [AW:0] NumLat = (AW + 1)'(N);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [1:0]      arb_gnt;
    logic            grant;
    logic            addr_ok;
    logic [AW-1:0]   win_addr;
    logic [W-1:0]    win_data;

    logic [1:0]      gnt_d, ack_d;
    logic            busy_d, err_d;
    logic [W-1:0]    lat_d_d;
    logic [N-1:0]    lat_en_d;

    assign grant    = (state_q == StIdle) && (req != 2'b00);
    assign win_addr = arb_gnt[1] ? addr1 : addr0;
    assign win_data = arb_gnt[1] ? data1 : data0;
    assign addr_ok  = {1'b0, addr_q} < NumLat;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .adv   (grant),
        .gnt   (arb_gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StSetup;
                    cnt_d   = CW'(SETUP_CYC - 1);
                    addr_d  = win_addr;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d = StOpen;
                    cnt_d   = CW'(OPEN_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StOpen: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                    cnt_d   = CW'(HOLD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are computed from the next state so every port comes straight from a flop.
    always_comb begin
        gnt_d   = gnt;
        lat_d_d = lat_d;
        if (state_d == StIdle) begin
            gnt_d = 2'b00;
        end else if (grant) begin
            gnt_d   = arb_gnt;
            lat_d_d = win_data;
        end
        busy_d = (state_d != StIdle);
        ack_d  = (state_d == StDone) ? gnt : 2'b00;
        err_d  = (state_d == StDone) && !addr_ok;
        // An out-of-range address matches no index, so the bank stays closed.
        for (int i = 0; i < int'(N); i++) begin
            lat_en_d[i] = (state_d == StOpen) && (addr_q == AW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt    <= 2'b00;
            ack    <= 2'b00;
            busy   <= 1'b0;
            err    <= 1'b0;
            lat_d  <= '0;
            lat_en <= '0;
        end else begin
            gnt    <= gnt_d;
            ack    <= ack_d;
            busy   <= busy_d;
            err    <= err_d;
            lat_d  <= lat_d_d;
            lat_en <= lat_en_d;
        end
    end

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Scoreboard bench: expected acks are queued by the stimulus and checked by per-DUT monitors.
module tb_latch_bank_ctrl;

    typedef struct {
        logic [1:0] gnt;
        logic       err;
        logic [7:0] latd;
        logic [7:0] en;
        int         opn;
        int         gap;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       req0_r, req1_r;
    logic [1:0] req;
    logic [1:0] addr0, addr1;
    logic [7:0] data0, data1;
    logic [1:0] gnt, ack;
    logic       busy, err;
    logic [7:0] lat_d;
    logic [3:0] lat_en;

    logic [1:0] req5;
    logic [2:0] a50, a51;
    logic [7:0] d50, d51;
    logic [1:0] g5, k5;
    logic       b5, e5;
    logic [7:0] ld5;
    logic [4:0] en5;

    int   n_vec = 0;
    int   n_bad = 0;
    int   hazards = 0;
    exp_t q4[$];
    exp_t q5[$];

    assign req = {req1_r, req0_r};

    latch_bank_ctrl u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .addr0  (addr0),
        .addr1  (addr1),
        .data0  (data0),
        .data1  (data1),
        .gnt    (gnt),
        .ack    (ack),
        .busy   (busy),
        .err    (err),
        .lat_d  (lat_d),
        .lat_en (lat_en)
    );

    latch_bank_ctrl #(.N(5)) u_dut5 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req5),
        .addr0  (a50),
        .addr1  (a51),
        .data0  (d50),
        .data1  (d51),
        .gnt    (g5),
        .ack    (k5),
        .busy   (b5),
        .err    (e5),
        .lat_d  (ld5),
        .lat_en (en5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endfunction

    function automatic exp_t mk(input logic [1:0] g, input logic e, input logic [7:0] d,
                                input logic [7:0] en, input int opn, input int gap);
        exp_t x;
        x.gnt = g; x.err = e; x.latd = d; x.en = en; x.opn = opn; x.gap = gap;
        return x;
    endfunction

    task automatic score(input string tag, input exp_t e, input logic [1:0] g, input logic [1:0] a,
                         input logic er, input logic [7:0] ld, input logic [7:0] eo,
                         input int opn, input int lat, input int gap);
        chk({tag, "_gnt"}, 32'(g), 32'(e.gnt));
        chk({tag, "_ack"}, 32'(a), 32'(e.gnt));
        chk({tag, "_err"}, 32'(er), 32'(e.err));
        chk({tag, "_lat_d"}, 32'(ld), 32'(e.latd));
        chk({tag, "_en_mask"}, 32'(eo), 32'(e.en));
        chk({tag, "_open_cycles"}, opn, e.opn);
        chk({tag, "_latency"}, lat, 5);
        if (e.gap >= 0) chk({tag, "_ack_gap"}, gap, e.gap);
    endtask

    // Monitor for the default-parameter DUT.
    initial begin
        int cyc = 0, start = 0, last = 0, opn = 0;
        logic [3:0] eo = '0;
        logic [1:0] pg = '0;
        logic [7:0] pld = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (gnt != 2'b00 && pg == 2'b00) begin
                    start = cyc; eo = '0; opn = 0;
                end
                if (lat_en != '0) begin
                    eo = eo | lat_en;
                    opn++;
                    if (lat_d !== pld) hazards++;
                end
                if ($countones(lat_en) > 1) hazards++;
                if (ack != 2'b00 || err) begin
                    if (q4.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL dut4_unexpected_ack: got ack=%b err=%b, expected none", ack, err);
                    end else begin
                        e = q4.pop_front();
                        score("dut4", e, gnt, ack, err, lat_d, {4'b0, eo}, opn, cyc - start,
                              cyc - last);
                    end
                    last = cyc;
                end
            end
            pg = gnt;
            pld = lat_d;
        end
    end

    // Monitor for the N=5 DUT.
    initial begin
        int cyc = 0, start = 0, last = 0, opn = 0;
        logic [4:0] eo = '0;
        logic [1:0] pg = '0;
        logic [7:0] pld = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (g5 != 2'b00 && pg == 2'b00) begin
                    start = cyc; eo = '0; opn = 0;
                end
                if (en5 != '0) begin
                    eo = eo | en5;
                    opn++;
                    if (ld5 !== pld) hazards++;
                end
                if ($countones(en5) > 1) hazards++;
                if (k5 != 2'b00 || e5) begin
                    if (q5.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL dut5_unexpected_ack: got ack=%b err=%b, expected none", k5, e5);
                    end else begin
                        e = q5.pop_front();
                        score("dut5", e, g5, k5, e5, ld5, {3'b0, eo}, opn, cyc - start, cyc - last);
                    end
                    last = cyc;
                end
            end
            pg = g5;
            pld = ld5;
        end
    end

    // Raise a request, optionally drop it once the enable opens, release it on its ack.
    task automatic requester(input int i, input logic [1:0] a, input logic [7:0] d, input bit drop);
        bit got = 0;
        if (i == 0) begin addr0 = a; data0 = d; req0_r = 1'b1; end
        else        begin addr1 = a; data1 = d; req1_r = 1'b1; end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (drop && lat_en != '0) req0_r = 1'b0;
            if (ack[i]) begin got = 1; break; end
        end
        if (!got) begin
            n_vec++; n_bad++;
            $display("FAIL ack_timeout_req%0d: got no ack, expected ack within 40 cycles", i);
        end
        if (i == 0) req0_r = 1'b0;
        else        req1_r = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req0_r = 1'b0; req1_r = 1'b0;
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        req5 = '0; a50 = '0; a51 = '0; d50 = '0; d51 = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_lat_d", 32'(lat_d), 0);
        chk("rst_lat_en", 32'(lat_en), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write.
        q4.push_back(mk(2'b01, 1'b0, 8'hA5, 8'h04, 2, -1));
        requester(0, 2'd2, 8'hA5, 1'b0);

        // Fairness: requester 1 alone, then a tie goes to requester 0.
        q4.push_back(mk(2'b10, 1'b0, 8'h3C, 8'h02, 2, -1));
        requester(1, 2'd1, 8'h3C, 1'b0);
        q4.push_back(mk(2'b01, 1'b0, 8'h5A, 8'h08, 2, 7));
        q4.push_back(mk(2'b10, 1'b0, 8'hC3, 8'h01, 2, 7));
        fork
            requester(0, 2'd3, 8'h5A, 1'b0);
            requester(1, 2'd0, 8'hC3, 1'b0);
        join

        // Early request drop during OPEN.
        q4.push_back(mk(2'b01, 1'b0, 8'h96, 8'h08, 2, -1));
        requester(0, 2'd3, 8'h96, 1'b1);

        // Reset while the enable is open; requester 0 wins so the pointer sits at 1.
        addr0 = 2'd1; data0 = 8'h77; req0_r = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (lat_en == 4'b0010) break;
        end
        chk("reach_open_lat_en", 32'(lat_en), 32'h2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0_r = 1'b0;
        chk("post_rst_lat_en", 32'(lat_en), 0);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_gnt", 32'(gnt), 0);
        chk("post_rst_ack", 32'(ack), 0);
        chk("post_rst_lat_d", 32'(lat_d), 0);
        repeat (10) @(negedge clk);

        // Contention after reset: pointer is back at 0.
        q4.push_back(mk(2'b01, 1'b0, 8'hE7, 8'h04, 2, -1));
        q4.push_back(mk(2'b10, 1'b0, 8'h18, 8'h08, 2, 7));
        fork
            requester(0, 2'd2, 8'hE7, 1'b0);
            requester(1, 2'd3, 8'h18, 1'b0);
        join

        // Out-of-range address on the N=5 bank.
        q5.push_back(mk(2'b01, 1'b1, 8'hE1, 8'h00, 0, -1));
        a50 = 3'd7; d50 = 8'hE1; req5 = 2'b01;
        begin
            bit got5 = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (k5[0]) begin got5 = 1; break; end
            end
            if (!got5) begin
                n_vec++; n_bad++;
                $display("FAIL dut5_ack_timeout: got no ack, expected ack within 40 cycles");
            end
        end
        req5 = 2'b00;

        repeat (5) @(negedge clk);
        chk("dut4_queue_left", q4.size(), 0);
        chk("dut5_queue_left", q5.size(), 0);
        chk("enable_hazards", hazards, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/latch_bank_ctrl.md
# latch_bank_ctrl

Write controller and arbiter for a bank of level-sensitive D latches. It shares the bank between two requesters using round-robin arbitration. Each write is sequenced as setup, then enable-open, then hold, so a latch's D input never changes while its enable is high. This removes the glitch and transparency hazards of driving latches directly. It sits between requester logic and the latch array; latch Q outputs are not routed back through it.

## Interface
- W, default 8: data width of every latch.
- N, default 4: number of latches in the bank; address width AW = $clog2(N).
- SETUP_CYC, default 2: cycles lat_d is stable before the enable opens; must be ≥1.
- OPEN_CYC, default 2: cycles the enable is high; must be ≥1.
- HOLD_CYC, default 1: cycles lat_d is held after the enable closes; must be ≥1.

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- req  in  2  write request; bit i belongs to requester i and is held until ack[i].
- addr0, addr1  in  AW  target latch index per requester.
- data0, data1  in  W  write data per requester.
- gnt  out  2  one-hot; high for the whole transaction of the granted requester.
- ack  out  2  one-cycle completion pulse to the granted requester.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse when a granted address is ≥ N.
- lat_d  out  W  data bus shared by all latches.
- lat_en  out  N  per-latch enable; one-hot or zero.

## Operation
- Reset values: state IDLE, gnt=0, ack=0, busy=0, err=0, lat_d=0, lat_en=0, round-robin pointer = requester 0.
- States: IDLE → SETUP → OPEN → HOLD → DONE → IDLE.
  - A single down-counter is loaded on entry to SETUP, OPEN and HOLD with that phase's CYC−1.
  - Each phase exits when the counter reaches 0.
- IDLE: req is sampled here and nowhere else.
  - If any req bit is high, grant and go to SETUP.
  - If both are high, grant the requester the pointer names.
  - After every grant, the pointer moves to the other requester.
- On grant, capture the winner's addr and data into internal registers. lat_d takes the captured data on the same edge.
- SETUP: lat_en=0.
- OPEN: only lat_en[captured addr] is high.
- HOLD: lat_en=0.
- DONE: ack[granted]=1 for one cycle; gnt drops on the edge that leaves DONE.
- lat_d holds its value through IDLE until the next grant. It never changes while any lat_en bit is high.
- Deasserting req mid-transaction has no effect: the transaction completes and is acked.
- addr ≥ N (only possible when N is not a power of two):
  - the sequence runs with lat_en held at 0;
  - err pulses in DONE together with ack.
- Reset mid-transaction:
  - on the reset edge lat_en goes to 0 and the state goes to IDLE;
  - no ack is issued and the pointer returns to 0;
  - the requester must re-request.

## Timing
- req is sampled high in IDLE at edge T.
- gnt and busy go high and SETUP starts at edge T+1.
- OPEN starts at T+1+SETUP_CYC.
- HOLD starts at T+1+SETUP_CYC+OPEN_CYC.
- DONE / ack at T+1+SETUP_CYC+OPEN_CYC+HOLD_CYC. With defaults, ack is high in the cycle starting at T+6.
- IDLE is entered one cycle after DONE. Back-to-back transactions are therefore spaced SETUP+OPEN+HOLD+2 cycles (7 with defaults).
- A requester that has no further data deasserts req on the edge that ends its ack cycle. A req still high in IDLE starts a new transaction.
- Every output is registered; none depends combinationally on an input.

## Structure
- Package latch_ctrl_pkg holds:
  - the state enum (IDLE, SETUP, OPEN, HOLD, DONE);
  - the phase-counter width, derived from the maximum of the three CYC parameters.
- Sub-module rr_arbiter2: two-requester round-robin arbiter with its pointer register. Inputs: req, an advance strobe pulsed on grant, rst_n. Output: a one-hot grant.
- The top level holds the FSM, the phase counter, the capture registers and the output registers.

## Test plan
- Single write: after reset, req=01, addr0=2, data0=8'hA5.
  - lat_d=A5 from T+1; lat_en=0100 from T+3 to T+4; ack=01 at T+6.
  - lat_en is never high while lat_d changes.
- Contention: req=11 held for two transactions.
  - Requester 0 is granted first, requester 1 second; the gnt sequence is 01 then 10.
  - Each receives exactly one ack, 7 cycles apart.
- Fairness: requester 1 alone, then both high.
  - Requester 0 wins the tie because the pointer advanced past 1.
- Early req drop: req0 falls during OPEN.
  - The transaction still completes and ack=01 is issued.
- Reset in OPEN: rst_n=0 for one edge while lat_en=0010.
  - Next cycle: lat_en=0, busy=0, gnt=0, no ack; lat_d=0.
- Parameter sweep: N=5, addr=7.
  - lat_en stays 0 for the whole transaction; err and ack pulse together in DONE.
